// File: rtl/i2c_clock_generator_param_if.sv
// Bus bundle between the I2C master datapath and the SCL timing generator.
// The generator sits on the slave modport; the controlling side uses master.
interface i2c_clock_generator_param_if #(
  parameter int CLK_FREQ_W = 30,
  parameter int BAUD_W     = 20
);
  logic                  Enable;
  logic                  Load;
  logic [BAUD_W-1:0]     BaudRate;
  logic [CLK_FREQ_W-1:0] ClockFrequency;
  logic                  SclIn;
  logic                  ClockI2C;
  logic [1:0]            Phase;
  logic                  QuarterTick;
  logic                  FallStrobe;
  logic                  RiseStrobe;
  logic                  Busy;
  logic                  Stretching;
  logic                  DivisorError;

  modport master (
    output Enable, Load, BaudRate, ClockFrequency, SclIn,
    input  ClockI2C, Phase, QuarterTick, FallStrobe, RiseStrobe,
           Busy, Stretching, DivisorError
  );

  modport slave (
    input  Enable, Load, BaudRate, ClockFrequency, SclIn,
    output ClockI2C, Phase, QuarterTick, FallStrobe, RiseStrobe,
           Busy, Stretching, DivisorError
  );
endinterface

// File: rtl/i2c_clock_generator_param.sv
// SCL timing generator: a restoring divider derives the quarter-bit count
// Q = ClockFrequency / (4*BaudRate), then a 4-phase sequencer drives SCL with stretch support.
module i2c_clock_generator_param #(
  parameter int CLK_FREQ_W = 30,
  parameter int BAUD_W     = 20
) (
  input logic                         clock,
  input logic                         Reset,
  i2c_clock_generator_param_if.slave  bus
);
  localparam int DVS_W = BAUD_W + 2;
  localparam int BIT_W = $clog2(CLK_FREQ_W);
  localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(CLK_FREQ_W - 1);
  localparam logic [BIT_W-1:0]      ONE_BIT  = BIT_W'(1);
  localparam logic [CLK_FREQ_W-1:0] ZERO_Q   = {CLK_FREQ_W{1'b0}};
  localparam logic [CLK_FREQ_W-1:0] ONE_Q    = CLK_FREQ_W'(1);
  localparam logic [DVS_W-1:0]      ZERO_DVS = {DVS_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CLK_FREQ_W-1:0] cnt_q, cnt_d;
  logic [1:0]            phase_q, phase_d;
  logic                  scl_q, scl_d;
  logic                  qtick_q, qtick_d;
  logic                  fall_q, fall_d;
  logic                  rise_q, rise_d;
  logic                  busy_q, busy_d;
  logic                  stretch_q, stretch_d;
  logic                  derr_q, derr_d;
  logic [CLK_FREQ_W-1:0] qdiv_q, qdiv_d;
  logic [CLK_FREQ_W-1:0] dvd_q, dvd_d;
  logic [DVS_W-1:0]      dvs_q, dvs_d;
  logic [DVS_W-1:0]      rem_q, rem_d;
  logic [CLK_FREQ_W-1:0] quo_q, quo_d;
  logic [BIT_W-1:0]      bit_q, bit_d;

  logic [DVS_W:0]        rem_shift_s;
  logic [DVS_W-1:0]      rem_sub_s;
  logic                  quo_bit_s;
  logic [CLK_FREQ_W-1:0] quo_next_s;
  logic                  wrap_s;
  logic                  hold_s;

  // next-state, divider step and registered-output computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    scl_d     = scl_q;
    qtick_d   = 1'b0;
    fall_d    = 1'b0;
    rise_d    = 1'b0;
    stretch_d = 1'b0;
    busy_d    = busy_q;
    derr_d    = derr_q;
    qdiv_d    = qdiv_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    bit_d     = bit_q;

    rem_shift_s = {rem_q, dvd_q[CLK_FREQ_W-1]};
    if (rem_shift_s >= {1'b0, dvs_q}) begin
      rem_sub_s = rem_shift_s[DVS_W-1:0] - dvs_q;
      quo_bit_s = 1'b1;
    end else begin
      rem_sub_s = rem_shift_s[DVS_W-1:0];
      quo_bit_s = 1'b0;
    end
    quo_next_s = {quo_q[CLK_FREQ_W-2:0], quo_bit_s};
    wrap_s     = (cnt_q == (qdiv_q - ONE_Q));
    // the first cycle of phase 2 is the bus rise allowance and never stretches
    hold_s     = phase_q[1] && !bus.SclIn && !((phase_q == 2'd2) && (cnt_q == ZERO_Q));

    if (bus.Load) begin
      state_d = ST_CALC;
      busy_d  = 1'b1;
      scl_d   = 1'b1;
      phase_d = 2'd0;
      cnt_d   = ZERO_Q;
      dvd_d   = bus.ClockFrequency;
      dvs_d   = {bus.BaudRate, 2'b00};
      rem_d   = ZERO_DVS;
      quo_d   = ZERO_Q;
      bit_d   = {BIT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.Enable && (qdiv_q != ZERO_Q)) begin
            state_d = ST_RUN;
            scl_d   = 1'b0;
            fall_d  = 1'b1;
            phase_d = 2'd0;
            cnt_d   = ZERO_Q;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CALC: begin
          dvd_d = dvd_q << 1;
          rem_d = rem_sub_s;
          quo_d = quo_next_s;
          bit_d = bit_q + ONE_BIT;
          if (bit_q == LAST_BIT) begin
            busy_d = 1'b0;
            if ((dvs_q == ZERO_DVS) || (quo_next_s == ZERO_Q)) begin
              derr_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              derr_d = 1'b0;
              qdiv_d = quo_next_s;
              if (bus.Enable) begin
                state_d = ST_RUN;
                scl_d   = 1'b0;
                fall_d  = 1'b1;
                phase_d = 2'd0;
                cnt_d   = ZERO_Q;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end else begin
            state_d = ST_CALC;
          end
        end
        ST_RUN: begin
          if (!bus.Enable) begin
            state_d = ST_IDLE;
            scl_d   = 1'b1;
            phase_d = 2'd0;
            cnt_d   = ZERO_Q;
          end else if (hold_s) begin
            stretch_d = 1'b1;
          end else if (wrap_s) begin
            cnt_d   = ZERO_Q;
            phase_d = phase_q + 2'd1;
            qtick_d = 1'b1;
            case (phase_q)
              2'd1: begin
                scl_d  = 1'b1;
                rise_d = 1'b1;
              end
              2'd3: begin
                scl_d  = 1'b0;
                fall_d = 1'b1;
              end
              default: begin
                scl_d = scl_q;
              end
            endcase
          end else begin
            cnt_d = cnt_q + ONE_Q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          scl_d   = 1'b1;
          phase_d = 2'd0;
          cnt_d   = ZERO_Q;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= ZERO_Q;
      phase_q   <= 2'd0;
      scl_q     <= 1'b1;
      qtick_q   <= 1'b0;
      fall_q    <= 1'b0;
      rise_q    <= 1'b0;
      busy_q    <= 1'b0;
      stretch_q <= 1'b0;
      derr_q    <= 1'b0;
      qdiv_q    <= ZERO_Q;
      dvd_q     <= ZERO_Q;
      dvs_q     <= ZERO_DVS;
      rem_q     <= ZERO_DVS;
      quo_q     <= ZERO_Q;
      bit_q     <= {BIT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      scl_q     <= scl_d;
      qtick_q   <= qtick_d;
      fall_q    <= fall_d;
      rise_q    <= rise_d;
      busy_q    <= busy_d;
      stretch_q <= stretch_d;
      derr_q    <= derr_d;
      qdiv_q    <= qdiv_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      bit_q     <= bit_d;
    end
  end

  assign bus.ClockI2C     = scl_q;
  assign bus.Phase        = phase_q;
  assign bus.QuarterTick  = qtick_q;
  assign bus.FallStrobe   = fall_q;
  assign bus.RiseStrobe   = rise_q;
  assign bus.Busy         = busy_q;
  assign bus.Stretching   = stretch_q;
  assign bus.DivisorError = derr_q;
endmodule

// File: tb/tb_i2c_clock_generator_param.sv
// Bench for i2c_clock_generator_param: directed scenarios plus random stimulus,
// every cycle compared against a position-in-bit reference model.
module tb_i2c_clock_generator_param;
  localparam int CFW = 30;
  localparam int BW  = 20;

  logic clock;
  logic Reset;

  i2c_clock_generator_param_if #(.CLK_FREQ_W(CFW), .BAUD_W(BW)) bus ();

  i2c_clock_generator_param #(.CLK_FREQ_W(CFW), .BAUD_W(BW)) dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: mode 0 idle, 1 computing, 2 running; m_el counts unfrozen run cycles
  int     m_mode;
  int     m_left;
  longint m_cf, m_baud, m_q, m_el;
  bit     m_err, m_qt, m_fall, m_rise, m_st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_cf = 0; m_baud = 0; m_q = 0; m_el = 0;
    m_err = 1'b0; m_qt = 1'b0; m_fall = 1'b0; m_rise = 1'b0; m_st = 1'b0;
  endtask

  task automatic start_run();
    m_mode = 2; m_el = 0; m_fall = 1'b1;
  endtask

  task automatic model_step();
    longint qn, pos;
    m_qt = 1'b0; m_fall = 1'b0; m_rise = 1'b0; m_st = 1'b0;
    if (bus.Load) begin
      m_mode = 1; m_left = CFW;
      m_cf = longint'(bus.ClockFrequency);
      m_baud = longint'(bus.BaudRate);
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) begin
        qn = (m_baud == 0) ? 0 : m_cf / (4 * m_baud);
        if (qn == 0) begin
          m_err = 1'b1; m_mode = 0;
        end else begin
          m_err = 1'b0; m_q = qn;
          if (bus.Enable) start_run(); else m_mode = 0;
        end
      end
    end else if (m_mode == 2) begin
      if (!bus.Enable) begin
        m_mode = 0;
      end else begin
        pos = m_el % (4 * m_q);
        if (pos > 2 * m_q - 1 && pos != 2 * m_q && !bus.SclIn) begin
          m_st = 1'b1;
        end else begin
          m_el++;
          pos = m_el % (4 * m_q);
          m_qt = (pos % m_q == 0);
          m_fall = (pos == 0);
          m_rise = (pos == 2 * m_q);
        end
      end
    end else if (bus.Enable && m_q != 0) begin
      start_run();
    end
  endtask

  task automatic check_all();
    int ph;
    bit scl;
    if (m_mode == 2) begin
      ph = int'((m_el % (4 * m_q)) / m_q);
      scl = (ph >= 2);
    end else begin
      ph = 0;
      scl = 1'b1;
    end
    chk("Busy",         32'(bus.Busy),         32'(m_mode == 1));
    chk("ClockI2C",     32'(bus.ClockI2C),     32'(scl));
    chk("Phase",        32'(bus.Phase),        32'(ph));
    chk("QuarterTick",  32'(bus.QuarterTick),  32'(m_qt));
    chk("FallStrobe",   32'(bus.FallStrobe),   32'(m_fall));
    chk("RiseStrobe",   32'(bus.RiseStrobe),   32'(m_rise));
    chk("Stretching",   32'(bus.Stretching),   32'(m_st));
    chk("DivisorError", 32'(bus.DivisorError), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clock);
    if (!Reset) model_reset(); else model_step();
    #1;
    check_all();
  endtask

  task automatic load(input int cf, input int br);
    bus.ClockFrequency = CFW'(cf);
    bus.BaudRate = BW'(br);
    bus.Load = 1'b1;
    tick();
    bus.Load = 1'b0;
  endtask

  task automatic wait_calc(output int n);
    n = int'(bus.Busy);
    for (int g = 0; g < 100; g++) begin
      tick();
      if (!bus.Busy) break;
      n++;
    end
  endtask

  task automatic cycles_to_fall(output int n);
    n = 0;
    for (int g = 0; g < 400; g++) begin
      tick();
      n++;
      if (bus.FallStrobe) break;
    end
  endtask

  task automatic measure(output int lo, output int hi);
    int g;
    lo = 0; hi = 0; g = 0;
    tick();
    while (!bus.FallStrobe && g < 400) begin tick(); g++; end
    while (!bus.ClockI2C && g < 400) begin lo++; tick(); g++; end
    while (bus.ClockI2C && g < 400) begin hi++; tick(); g++; end
  endtask

  task automatic async_reset();
    #3;
    Reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_scl", 32'(bus.ClockI2C), 32'd1);
    chk("async_rst_busy", 32'(bus.Busy), 32'd0);
    repeat (2) tick();
    Reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lo, hi, qt, st, ncyc;
    Reset = 1'b0;
    bus.Enable = 1'b0; bus.Load = 1'b0; bus.SclIn = 1'b1;
    bus.BaudRate = '0; bus.ClockFrequency = '0;
    model_reset();
    repeat (3) tick();
    chk("reset_scl", 32'(bus.ClockI2C), 32'd1);
    chk("reset_err", 32'(bus.DivisorError), 32'd0);
    Reset = 1'b1;

    // Q = 10/(4*2) = 1
    load(10, 2);
    wait_calc(n);
    chk("busy_len_q1", 32'(n), 32'd30);
    chk("model_q1", 32'(m_q), 32'd1);
    bus.Enable = 1'b1;
    tick();
    chk("q1_first_fall", 32'(bus.FallStrobe), 32'd1);
    qt = 0;
    repeat (8) begin tick(); qt += int'(bus.QuarterTick); end
    chk("q1_qtick_count", 32'(qt), 32'd8);
    measure(lo, hi);
    chk("q1_low", 32'(lo), 32'd2);
    chk("q1_high", 32'(hi), 32'd2);

    // Q = 100/20 = 5, reloaded while running
    load(100, 5);
    wait_calc(n);
    chk("busy_len_q5", 32'(n), 32'd30);
    chk("model_q5", 32'(m_q), 32'd5);
    measure(lo, hi);
    chk("q5_low", 32'(lo), 32'd10);
    chk("q5_high", 32'(hi), 32'd10);

    // slave holds SCL low for 7 cycles starting 2 cycles into phase 2
    n = 0;
    while (!bus.RiseStrobe && n < 400) begin tick(); n++; end
    hi = 1;
    repeat (2) begin tick(); hi += int'(bus.ClockI2C); end
    bus.SclIn = 1'b0;
    st = 0; qt = 0;
    repeat (7) begin
      tick();
      hi += int'(bus.ClockI2C);
      st += int'(bus.Stretching);
      qt += int'(bus.QuarterTick);
    end
    bus.SclIn = 1'b1;
    for (int g = 0; g < 100; g++) begin
      tick();
      if (bus.FallStrobe) break;
      hi += int'(bus.ClockI2C);
    end
    chk("stretch_cycles", 32'(st), 32'd7);
    chk("stretch_no_qtick", 32'(qt), 32'd0);
    chk("stretch_high", 32'(hi), 32'd17);

    // drop Enable in phase 1, then re-enable
    repeat (7) tick();
    bus.Enable = 1'b0;
    tick();
    chk("drop_scl", 32'(bus.ClockI2C), 32'd1);
    chk("drop_phase", 32'(bus.Phase), 32'd0);
    repeat (3) tick();
    bus.Enable = 1'b1;
    tick();
    chk("reen_fall", 32'(bus.FallStrobe), 32'd1);
    cycles_to_fall(n);
    chk("reen_period", 32'(n), 32'd20);

    // invalid divisors keep Q
    bus.Enable = 1'b0;
    tick();
    load(100, 0);
    wait_calc(n);
    chk("err_baud0", 32'(bus.DivisorError), 32'd1);
    bus.Enable = 1'b1;
    tick();
    chk("err_run_fall", 32'(bus.FallStrobe), 32'd1);
    cycles_to_fall(n);
    chk("err_q_kept", 32'(n), 32'd20);
    load(10, 20);
    wait_calc(n);
    chk("err_q0", 32'(bus.DivisorError), 32'd1);
    chk("err_idle_scl", 32'(bus.ClockI2C), 32'd1);
    tick();
    chk("err_restart", 32'(bus.FallStrobe), 32'd1);
    load(100, 5);
    wait_calc(n);
    chk("err_cleared", 32'(bus.DivisorError), 32'd0);

    // asynchronous reset during computation and during running
    load(40, 1);
    repeat (10) tick();
    async_reset();
    repeat (5) tick();
    chk("no_run_q0", 32'(bus.ClockI2C), 32'd1);
    load(100, 5);
    wait_calc(n);
    repeat (13) tick();
    async_reset();
    tick();

    // randomized traffic
    bus.Enable = 1'b1;
    for (int s = 0; s < 50; s++) begin
      if ($urandom_range(0, 2) != 0) load(int'($urandom_range(0, 300)), int'($urandom_range(0, 12)));
      ncyc = int'($urandom_range(30, 150));
      for (int c = 0; c < ncyc; c++) begin
        bus.SclIn = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 39) == 0) bus.Enable = ~bus.Enable;
        bus.Load = ($urandom_range(0, 149) == 0);
        if (bus.Load) begin
          bus.ClockFrequency = CFW'($urandom_range(0, 300));
          bus.BaudRate = BW'($urandom_range(0, 12));
        end
        tick();
      end
      bus.Load = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_clock_generator_param.md
Name: i2c_clock_generator_param

Overview:
Parametrised I2C SCL timing generator for the I2C master datapath. It derives a quarter-period divisor from ClockFrequency and BaudRate using an on-chip sequential divider. It then produces ClockI2C, a 4-phase quarter-bit sequencer with edge strobes, and supports slave clock stretching. Runtime divisor reload and divisor-error detection are included.

Parameters:
CLK_FREQ_W, 30, width of ClockFrequency, quotient, and quarter counter
BAUD_W, 20, width of BaudRate

Ports:
clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Enable  input  1  run SCL generation when high
Load  input  1  single-cycle pulse; capture BaudRate/ClockFrequency and recompute divisor
BaudRate  input  BAUD_W  SCL frequency in Hz
ClockFrequency  input  CLK_FREQ_W  system clock frequency in Hz
SclIn  input  1  synchronised SCL bus level, for stretch detection
ClockI2C  output  1  generated SCL; 1 = released/high
Phase  output  2  current quarter-bit phase 0..3
QuarterTick  output  1  one-cycle pulse at end of each quarter
FallStrobe  output  1  one-cycle pulse when ClockI2C goes 1->0
RiseStrobe  output  1  one-cycle pulse when ClockI2C goes 0->1
Busy  output  1  divisor computation in progress
Stretching  output  1  high while count is frozen by slave stretch
DivisorError  output  1  sticky; last Load produced an invalid divisor

Behaviour:
- Reset low (asynchronous) sets:
  - state IDLE
  - ClockI2C=1, Phase=0
  - all strobes=0, Busy=0, Stretching=0, DivisorError=0
  - divisor Q=0, counter=0
- States: IDLE, CALC, RUN.
- Divisor computation:
  - Q = floor(ClockFrequency / (4*BaudRate)).
  - Divisor operand is BAUD_W+2 bits wide; quotient is CLK_FREQ_W bits.
  - Restoring divider, one quotient bit per cycle.
- Load, accepted in any state:
  - Operands are latched on the Load cycle.
  - Next cycle: state CALC, Busy=1, ClockI2C=1, Phase=0, counter=0.
  - CALC lasts exactly CLK_FREQ_W cycles; Busy is cleared on the cycle Q is written.
- End of CALC:
  - If BaudRate==0 or quotient==0: DivisorError=1, Q unchanged, go to IDLE.
  - Otherwise: DivisorError=0, Q updated, go to RUN if Enable else IDLE.
- Load during CALC restarts the computation with the new operands.
- IDLE -> RUN when Enable=1 and Q!=0.
  - The first RUN cycle has Phase=0 and ClockI2C=0, with FallStrobe pulsed in that cycle.
- RUN counting:
  - Counter counts 0..Q-1.
  - At count Q-1: QuarterTick=1, counter wraps to 0, Phase increments mod 4.
- ClockI2C is 0 in phases 0 and 1, and 1 in phases 2 and 3.
  - RiseStrobe pulses with the cycle Phase becomes 2.
  - FallStrobe pulses with the cycle Phase wraps 3->0.
- Strobes are registered and coincide with the ClockI2C change.
- Clock stretching:
  - Applies in RUN with Phase 2 or 3 and SclIn==0, excluding the first cycle of phase 2 (bus rise allowance).
  - Counter and Phase freeze, QuarterTick suppressed, Stretching=1.
  - Counting resumes the cycle after SclIn==1.
- Enable deasserted in RUN:
  - Next cycle: IDLE, ClockI2C=1, Phase=0, counter=0, no strobes.
  - Any partial bit is abandoned.
- Simultaneous Load and Enable edge: Load has priority.
- Q==1 is legal: every cycle is a QuarterTick, SCL period is 4 clocks.
- Reset asserted mid-CALC or mid-RUN aborts immediately to reset values, including Q=0.

Test Plan:
- Reset=0 then 1, Load with ClockFrequency=10, BaudRate=2 (CLK_FREQ_W=30) -> Busy high 30 cycles, Q=1. Enable=1 -> ClockI2C period 4 clocks (2 low, 2 high), QuarterTick every cycle.
- ClockFrequency=100, BaudRate=5, Enable=1 -> Q=5, ClockI2C 10 low / 10 high, FallStrobe every 20 clocks, Phase sequence 0,1,2,3.
- Load with BaudRate=0, then BaudRate=20 with ClockFrequency=10 -> DivisorError=1 both times, Q keeps its prior value, running clock unaffected only if state was IDLE.
- Q=5 and SclIn held 0 for 7 cycles starting 2 cycles into phase 2 -> Stretching=1 for 7 cycles, high time extended to 17 clocks, no QuarterTick during the hold.
- Enable dropped mid-phase 1 -> next cycle ClockI2C=1, Phase=0. Re-enable -> FallStrobe on the first cycle, then a full 4Q-clock period.
- Reset pulsed low during CALC and during RUN -> all outputs at reset values asynchronously, and Enable alone does not start RUN (Q=0).
